seg7_mux: RTL and testbench
===========================

SEG7_MUX -- requirements
Module: seg7_mux

Interface
REQ-001 SHALL have parameter BASE, default 12'h100: word address of register 0.
REQ-002 SHALL have parameter DIGITS, default 4: digit count, legal 1..8.
REQ-003 SHALL have parameter SCAN_DIV, default 1024: clk cycles per digit slot; legal values are multiples of 256.
REQ-004 SHALL have parameter ACTIVE_LOW, default 1: 1 means seg and an are driven active-low.
REQ-005 SHALL have port clk, input, 1 bit: sole clock; every flop is on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port enable, input, 1 bit: bus access qualifier.
REQ-008 SHALL have port rw, input, 1 bit: 1 = write, 0 = read.
REQ-009 SHALL have port addr, input, 32 bits: word address.
REQ-010 SHALL have port wdata, input, 32 bits: write data.
REQ-011 SHALL have port rdata, output, 32 bits: read data.
REQ-012 SHALL have port seg, output, 8 bits: segments a..g at [6:0], dp at [7].
REQ-013 SHALL have port an, output, DIGITS bits: digit strobes, bit 0 = rightmost digit.

Function
REQ-014 SHALL decode register map: BASE+0 VALUE, with 4 bits per digit, digit i at [4i+3:4i].
REQ-015 SHALL decode BASE+1 CTRL: [0] on, [1] raw, [2] leading-zero blank, [15:8] bright, [23:16] dp mask.
REQ-016 SHALL decode BASE+2+i, for i < DIGITS, as RAW[i], holding an 8-bit segment pattern in [7:0].
REQ-017 SHALL write a register in the cycle that enable=1, rw=1 and addr matches it; unused bits SHALL be ignored.
REQ-018 SHALL ignore writes to any other address, with no state change.
REQ-019 SHALL present rdata one cycle after enable=1, rw=0 with a matching addr; unused bits SHALL read 0.
REQ-020 SHALL present rdata = 0 one cycle after any non-matching read or idle cycle.
REQ-021 SHALL keep a prescaler counting 0..SCAN_DIV-1; on wrap the digit index SHALL advance, and index DIGITS-1 SHALL wrap to 0.
REQ-022 SHALL compute phase = prescaler / (SCAN_DIV/256), range 0..255; the digit is lit only while phase < bright.
REQ-023 SHALL give bright=0 a fully dark display and bright=255 a 255/256 duty.
REQ-024 SHALL, in hex mode (raw=0), map the digit nibble to its standard 0-F glyph; dp = dp mask bit of the current index.
REQ-025 SHALL, in raw mode (raw=1), drive seg = RAW[index] unmodified.
REQ-026 SHALL, with blank=1 and raw=0, blank every digit above the highest nonzero nibble; digit 0 SHALL never be blanked.
REQ-027 SHALL register seg and an, so they reflect index and phase with exactly 1 cycle latency.
REQ-028 SHALL assert exactly one an bit while lit, and none while dark or when on=0.
REQ-029 SHALL drive seg inactive whenever an is all inactive.
REQ-030 SHALL continue the scan when on=0, so re-enable resumes without a phase jump.
REQ-031 SHALL apply a register write to the display from the next cycle, even mid-slot; the prescaler SHALL not be disturbed.
REQ-032 SHALL invert seg and an at the output when ACTIVE_LOW=1.

Reset
REQ-033 SHALL, on reset, clear prescaler, index and VALUE to 0 and every RAW to 0.
REQ-034 SHALL, on reset, set CTRL to on=1, raw=0, blank=0, bright=255, dp=0.
REQ-035 SHALL drive seg and an inactive and rdata = 0 in the cycle after reset is sampled.
REQ-036 SHALL take reset mid-slot or mid-read with priority over any simultaneous bus write.

Structure
REQ-037 SHALL place register offsets, CTRL bit positions and the 16-entry hex glyph table in shared package seg7_pkg.
REQ-038 SHALL use one sub-module, seg7_scan, holding the prescaler, index and phase compare and outputting index and lit.
REQ-039 SHALL keep register file, bus decode and glyph mux in the top.

Verification
REQ-040 SHALL test scan order: reset, then VALUE=0x1234, SCAN_DIV=256 -> an steps digit 0,1,2,3,0 every 256 cycles and seg shows glyphs 4,3,2,1.
REQ-041 SHALL test brightness: bright=64 -> each slot lit for exactly 64 of 256 cycles; bright=0 -> an never asserted.
REQ-042 SHALL test raw mode: raw=1, RAW[2]=0xA5 -> seg = 0xA5 (inverted if ACTIVE_LOW) while digit 2 is lit.
REQ-043 SHALL test blanking: VALUE=0x0070, blank=1 -> digits 2,3 dark, digit 1 shows 7, digit 0 shows 0; VALUE=0 -> only digit 0 lit.
REQ-044 SHALL test the bus: read CTRL after reset -> 0x0000FF01 one cycle later; write BASE+9 (DIGITS=4) then read all registers -> unchanged; read unmapped address -> 0.
REQ-045 SHALL test reset in the middle of digit 2 with a simultaneous write VALUE=0xFFFF -> VALUE reads 0, scan restarts at digit 0, outputs inactive for one cycle.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the multiplexed seven-segment controller.
//   - Register word offsets relative to BASE (VALUE, CTRL, first RAW).
//   - CTRL field bit positions.
//   - Hex glyph table, active-high, segments a..g at bits [6:0].
package seg7_pkg;

  localparam int unsigned OFF_VALUE = 0;
  localparam int unsigned OFF_CTRL  = 1;
  localparam int unsigned OFF_RAW   = 2;

  localparam int unsigned CTRL_ON         = 0;
  localparam int unsigned CTRL_RAW        = 1;
  localparam int unsigned CTRL_BLANK      = 2;
  localparam int unsigned CTRL_BRIGHT_LSB = 8;
  localparam int unsigned CTRL_DP_LSB     = 16;

  localparam logic [7:0] RESET_BRIGHT = 8'hFF;

  localparam logic [6:0] HEX_GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,   // 0 1 2 3
    7'h66, 7'h6D, 7'h7D, 7'h07,   // 4 5 6 7
    7'h7F, 7'h6F, 7'h77, 7'h7C,   // 8 9 A b
    7'h39, 7'h5E, 7'h79, 7'h71    // C d E F
  };

endpackage

// File: rtl/seg7_scan.sv
// seg7_scan: digit scan timing.
//   clk, reset   : clock, synchronous active-high reset
//   bright_i     : slot brightness 0..255
//   index_o      : digit currently being scanned
//   lit_o        : high while the slot phase is below bright_i
// The prescaler (0..SCAN_DIV-1) is held as phase_q * SUB_DIV + sub_q, so the
// 0..255 phase falls out directly without a divider.
module seg7_scan #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 1024,
  parameter int IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       bright_i,
  output logic [IDX_W-1:0] index_o,
  output logic             lit_o
);

  localparam int SUB_DIV = SCAN_DIV / 256;
  localparam int SUB_W   = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;

  logic [SUB_W-1:0] sub_q, sub_d;
  logic [7:0]       phase_q, phase_d;
  logic [IDX_W-1:0] index_q, index_d;

  always_comb begin
    sub_d   = sub_q + SUB_W'(1);
    phase_d = phase_q;
    index_d = index_q;
    if (sub_q == SUB_W'(SUB_DIV - 1)) begin
      sub_d   = '0;
      phase_d = phase_q + 8'd1;
      if (phase_q == 8'hFF) begin
        index_d = (index_q == IDX_W'(DIGITS - 1)) ? '0 : index_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sub_q   <= '0;
      phase_q <= '0;
      index_q <= '0;
    end else begin
      sub_q   <= sub_d;
      phase_q <= phase_d;
      index_q <= index_d;
    end
  end

  assign index_o = index_q;
  // bright=0 never lights; bright=255 lights phases 0..254.
  assign lit_o   = (phase_q < bright_i);

endmodule

// File: rtl/seg7_mux.sv
// seg7_mux: bus-mapped multiplexed seven-segment display controller.
//   clk, reset      : clock, synchronous active-high reset
//   enable, rw      : bus access qualifier, 1 = write / 0 = read
//   addr, wdata     : word address and write data
//   rdata           : registered read data (0 when no matching read)
//   seg             : segments a..g [6:0], dp [7]
//   an              : digit strobes, bit 0 = rightmost
// Register map: BASE+0 VALUE, BASE+1 CTRL, BASE+2+i RAW[i].
// Bus handshake: a request is the single cycle with enable=1; writes take
// effect at that clock edge, read data is valid the following cycle. There is
// no stall: the bus is always ready.
module seg7_mux
  import seg7_pkg::*;
#(
  parameter logic [11:0] BASE       = 12'h100,
  parameter int          DIGITS     = 4,
  parameter int          SCAN_DIV   = 1024,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              rw,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic [7:0]        seg,
  output logic [DIGITS-1:0] an
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int VW    = 4 * DIGITS;

  // Register file
  logic [VW-1:0] value_q;
  logic          on_q, raw_q, blank_q;
  logic [7:0]    bright_q, dp_q;
  logic [7:0]    raw_pat_q [DIGITS];

  // Bus decode: offsets below BASE wrap to large values and miss.
  logic [31:0] off;
  logic        hit, wr_en, rd_en;

  assign off   = addr - {20'd0, BASE};
  assign hit   = (off < 32'(OFF_RAW + DIGITS));
  assign wr_en = enable && rw && hit;
  assign rd_en = enable && !rw && hit;

  logic unused_wdata;
  assign unused_wdata = ^wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      value_q  <= '0;
      on_q     <= 1'b1;
      raw_q    <= 1'b0;
      blank_q  <= 1'b0;
      bright_q <= RESET_BRIGHT;
      dp_q     <= '0;
      for (int i = 0; i < DIGITS; i++) raw_pat_q[i] <= '0;
    end else if (wr_en) begin
      if (off == 32'(OFF_VALUE)) value_q <= wdata[VW-1:0];
      if (off == 32'(OFF_CTRL)) begin
        on_q     <= wdata[CTRL_ON];
        raw_q    <= wdata[CTRL_RAW];
        blank_q  <= wdata[CTRL_BLANK];
        bright_q <= wdata[CTRL_BRIGHT_LSB +: 8];
        dp_q     <= wdata[CTRL_DP_LSB +: 8];
      end
      for (int i = 0; i < DIGITS; i++) begin
        if (off == 32'(OFF_RAW + i)) raw_pat_q[i] <= wdata[7:0];
      end
    end
  end

  // Read path
  logic [31:0] rdata_d, rdata_q;

  always_comb begin
    rdata_d = '0;
    if (rd_en) begin
      if (off == 32'(OFF_VALUE)) rdata_d[VW-1:0] = value_q;
      if (off == 32'(OFF_CTRL)) begin
        rdata_d[CTRL_ON]               = on_q;
        rdata_d[CTRL_RAW]              = raw_q;
        rdata_d[CTRL_BLANK]            = blank_q;
        rdata_d[CTRL_BRIGHT_LSB +: 8]  = bright_q;
        rdata_d[CTRL_DP_LSB +: 8]      = dp_q;
      end
      for (int i = 0; i < DIGITS; i++) begin
        if (off == 32'(OFF_RAW + i)) rdata_d[7:0] = raw_pat_q[i];
      end
    end
  end

  // Scan timing
  logic [IDX_W-1:0] index;
  logic             lit;

  seg7_scan #(
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV),
    .IDX_W    (IDX_W)
  ) u_scan (
    .clk      (clk),
    .reset    (reset),
    .bright_i (bright_q),
    .index_o  (index),
    .lit_o    (lit)
  );

  // Glyph mux. Shifting VALUE down to the current digit gives both the nibble
  // and the "all higher digits are zero" test used for leading-zero blanking.
  logic [VW-1:0]     shifted;
  logic [DIGITS-1:0] dp_digits;
  logic              blank_digit, show;
  logic [7:0]        pattern, seg_ah, seg_d, seg_q;
  logic [DIGITS-1:0] an_ah, an_d, an_q;

  assign shifted   = value_q >> {index, 2'b00};
  assign dp_digits = dp_q[DIGITS-1:0];

  always_comb begin
    blank_digit = blank_q && !raw_q && (index != '0) && (shifted == '0);
    show        = on_q && lit && !blank_digit;
    pattern     = raw_q ? raw_pat_q[index]
                        : {dp_digits[index], HEX_GLYPH[shifted[3:0]]};
    seg_ah      = show ? pattern : 8'h00;
    an_ah       = show ? (DIGITS'(1) << index) : '0;
    seg_d       = ACTIVE_LOW ? ~seg_ah : seg_ah;
    an_d        = ACTIVE_LOW ? ~an_ah  : an_ah;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seg_q   <= {8{ACTIVE_LOW}};
      an_q    <= {DIGITS{ACTIVE_LOW}};
      rdata_q <= '0;
    end else begin
      seg_q   <= seg_d;
      an_q    <= an_d;
      rdata_q <= rdata_d;
    end
  end

  assign seg   = seg_q;
  assign an    = an_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_seg7_mux.sv
module tb_seg7_mux;

  localparam logic [31:0] BASE = 32'h100;

  // Clock / reset
  logic        clk = 1'b0;
  logic        reset, enable, rw;
  logic [31:0] addr, wdata, rdata;
  logic [7:0]  seg;
  logic [3:0]  an;

  always #5 clk = ~clk;

  seg7_mux #(
    .BASE       (12'h100),
    .DIGITS     (4),
    .SCAN_DIV   (256),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .rw     (rw),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .seg    (seg),
    .an     (an)
  );

  // Reference model: time-based view of the display.
  logic [6:0]  glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                                  7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h77, 7'h7C,
                                  7'h39, 7'h5E, 7'h79, 7'h71};
  int unsigned t;           // cycles since reset release
  logic [15:0] m_value;
  logic [31:0] m_ctrl;
  logic [7:0]  m_raw [4];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    t       = 0;
    m_value = '0;
    m_ctrl  = 32'h0000FF01;
    for (int i = 0; i < 4; i++) m_raw[i] = '0;
  endtask

  task automatic model_out(output logic [7:0] es, output logic [3:0] ea);
    int         idx, phase, upper;
    logic       lit, blanked;
    logic [7:0] pat;
    idx     = int'((t / 256) % 4);
    phase   = int'(t % 256);
    upper   = int'(m_value) >> (4 * idx);
    lit     = m_ctrl[0] && (phase < int'(m_ctrl[15:8]));
    blanked = m_ctrl[2] && !m_ctrl[1] && (idx != 0) && (upper == 0);
    pat     = m_ctrl[1] ? m_raw[idx] : {m_ctrl[16 + idx], glyph_tab[upper % 16]};
    if (lit && !blanked) begin
      es = ~pat;
      ea = ~(4'b0001 << idx);
    end else begin
      es = 8'hFF;
      ea = 4'hF;
    end
  endtask

  function automatic logic [31:0] model_read();
    logic [31:0] off;
    off = addr - BASE;
    if (!(enable && !rw) || off >= 6) return 32'h0;
    if (off == 0) return {16'h0, m_value};
    if (off == 1) return m_ctrl;
    return {24'h0, m_raw[off - 2]};
  endfunction

  task automatic model_write();
    logic [31:0] off;
    off = addr - BASE;
    if (enable && rw && off < 6) begin
      if (off == 0) m_value = wdata[15:0];
      else if (off == 1) m_ctrl = wdata & 32'h00FFFF07;
      else m_raw[off - 2] = wdata[7:0];
    end
  endtask

  // One clock: predict, advance, then compare away from the edge.
  task automatic step();
    logic [7:0]  es;
    logic [3:0]  ea;
    logic [31:0] er;
    logic        was_reset;
    was_reset = reset;
    if (was_reset) begin
      es = 8'hFF; ea = 4'hF; er = 32'h0;
    end else begin
      model_out(es, ea);
      er = model_read();
    end
    @(posedge clk);
    if (was_reset) model_reset();
    else begin
      model_write();
      t++;
    end
    #1;
    check("seg", {24'h0, seg}, {24'h0, es});
    check("an", {28'h0, an}, {28'h0, ea});
    check("rdata", rdata, er);
  endtask

  // Driver tasks
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    enable = 1'b1; rw = 1'b1; addr = a; wdata = d;
    step();
    enable = 1'b0; rw = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    enable = 1'b1; rw = 1'b0; addr = a;
    step();
    enable = 1'b0;
    d = rdata;
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; rw = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic run_to_phase(input int unsigned mod, input int unsigned target);
    while (t % mod != target) step();
  endtask

  logic [31:0] d;
  logic [3:0]  exp_an  [5] = '{4'hE, 4'hD, 4'hB, 4'h7, 4'hE};
  logic [7:0]  exp_seg [5] = '{8'h99, 8'hB0, 8'hA4, 8'hF9, 8'h99};
  int          lit_cnt [4];
  logic [7:0]  last_seg [4];
  int          dark_viol;

  task automatic scan_slots(input int n);
    for (int i = 0; i < 4; i++) begin lit_cnt[i] = 0; last_seg[i] = 8'h00; end
    dark_viol = 0;
    repeat (n) begin
      step();
      for (int i = 0; i < 4; i++) begin
        if (an[i] == 1'b0) begin lit_cnt[i]++; last_seg[i] = seg; end
      end
      if (an == 4'hF && seg != 8'hFF) dark_viol++;
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; rw = 1'b0; addr = '0; wdata = '0;
    model_reset();
    repeat (3) step();
    reset = 1'b0;

    // Bus: reset values, ignored write, unmapped reads
    bus_read(BASE + 1, d);
    check("ctrl_after_reset", d, 32'h0000FF01);
    bus_write(BASE + 9, 32'hDEADBEEF);
    bus_read(BASE + 0, d); check("value_unchanged", d, 32'h0);
    bus_read(BASE + 1, d); check("ctrl_unchanged", d, 32'h0000FF01);
    for (int i = 0; i < 4; i++) begin
      bus_read(BASE + 2 + i, d); check("raw_unchanged", d, 32'h0);
    end
    bus_read(32'h200, d);    check("unmapped_read", d, 32'h0);
    bus_read(BASE - 1, d);   check("below_base_read", d, 32'h0);

    // Scan order with VALUE=0x1234
    do_reset();
    bus_write(BASE, 32'h1234);
    for (int k = 0; k < 5; k++) begin
      while (t < 256 * k + 129) step();
      check("scan_an", {28'h0, an}, {28'h0, exp_an[k]});
      check("scan_seg", {24'h0, seg}, {24'h0, exp_seg[k]});
    end

    // Brightness 64, then 0
    bus_write(BASE + 1, 32'h0000_4001);
    run_to_phase(1024, 0);
    scan_slots(1024);
    for (int i = 0; i < 4; i++) check("bright64_lit", lit_cnt[i], 64);
    check("dark_seg_inactive", dark_viol, 0);
    bus_write(BASE + 1, 32'h0000_0001);
    scan_slots(1024);
    check("bright0_lit", lit_cnt[0] + lit_cnt[1] + lit_cnt[2] + lit_cnt[3], 0);

    // Raw mode
    bus_write(BASE + 1, 32'h0000_FF03);
    bus_write(BASE + 4, 32'h0000_00A5);
    run_to_phase(1024, 613);
    check("raw_seg", {24'h0, seg}, 32'h5A);
    check("raw_an", {28'h0, an}, 32'hB);

    // Leading-zero blanking
    bus_write(BASE + 1, 32'h0000_FF05);
    bus_write(BASE, 32'h0000_0070);
    run_to_phase(1024, 0);
    scan_slots(1024);
    check("blank_d3", lit_cnt[3], 0);
    check("blank_d2", lit_cnt[2], 0);
    check("blank_d1_lit", lit_cnt[1], 255);
    check("blank_d1_seg", {24'h0, last_seg[1]}, 32'hF8);
    check("blank_d0_lit", lit_cnt[0], 255);
    check("blank_d0_seg", {24'h0, last_seg[0]}, 32'hC0);
    bus_write(BASE, 32'h0);
    run_to_phase(1024, 0);
    scan_slots(1024);
    check("zero_only_d0", lit_cnt[0], 255);
    check("zero_others", lit_cnt[1] + lit_cnt[2] + lit_cnt[3], 0);

    // Randomized bus traffic against the model
    for (int iter = 0; iter < 60; iter++) begin
      case ($urandom_range(0, 3))
        0: bus_write(BASE + $urandom_range(0, 9), $urandom);
        1: bus_read(BASE + $urandom_range(0, 7), d);
        2: bus_write(BASE + 1, $urandom | 32'h1);
        default: repeat ($urandom_range(1, 300)) step();
      endcase
    end

    // Reset mid digit 2 with a simultaneous VALUE write
    bus_write(BASE + 1, 32'h0000_FF01);
    run_to_phase(1024, 600);
    reset = 1'b1; enable = 1'b1; rw = 1'b1; addr = BASE; wdata = 32'hFFFF;
    step();
    check("rst_seg_inactive", {24'h0, seg}, 32'hFF);
    check("rst_an_inactive", {28'h0, an}, 32'hF);
    check("rst_rdata", rdata, 32'h0);
    reset = 1'b0; enable = 1'b0; rw = 1'b0;
    step();
    check("rst_restart_an", {28'h0, an}, 32'hE);
    check("rst_restart_seg", {24'h0, seg}, 32'hC0);
    bus_read(BASE, d);
    check("rst_value_cleared", d, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
